// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for seg7_scan_driver.
//   value    : 16-bit display word, nibble k drives digit k (digit 0 rightmost)
//   dp_en    : per-digit decimal-point enable
//   blank_lz : blank leading zeros when set
//   an       : anode enables, active-low, an[k] selects digit k
//   seg      : cathodes {g,f,e,d,c,b,a}, active-low
//   dp       : decimal-point cathode, active-low
//   frame    : one-cycle pulse following each snapshot of the inputs
// The master drives the display word; the slave is the scan driver.
interface seg7_scan_driver_if;
   logic [15:0] value;
   logic [3:0]  dp_en;
   logic        blank_lz;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame;

   modport master (
      output value, dp_en, blank_lz,
      input  an, seg, dp, frame
   );

   modport slave (
      input  value, dp_en, blank_lz,
      output an, seg, dp, frame
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit time-multiplexed seven-segment driver for a common-anode display.
// One digit is lit at a time for SCAN_PERIOD cycles, order 0,1,2,3. The display
// inputs are snapshotted once per frame so a mid-frame update never tears.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : seg7_scan_driver_if.slave (value/dp_en/blank_lz in, an/seg/dp/frame out)
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_DARK | no snapshot since reset; display dark until the first tick
// ST_SCAN | shadow valid; idx walks digits 0..3, snapshot on idx 3 tick
module seg7_scan_driver #(
   parameter int SCAN_PERIOD = 100_000
) (
   input logic                clk,
   input logic                rst,
   seg7_scan_driver_if.slave  bus
);

   localparam int              CNT_W    = $clog2(SCAN_PERIOD);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_PERIOD - 1);

   typedef enum logic {
      ST_DARK = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       idx;
   logic [15:0]      sh_value;
   logic [3:0]       sh_dp_en;
   logic             sh_blank_lz;

   logic [3:0]       an_q;
   logic [6:0]       seg_q;
   logic             dp_q;
   logic             frame_q;

   logic             tick;
   logic             snap;
   logic [3:0]       zero_from;
   logic [3:0]       nib;
   logic             blank;
   logic [3:0]       an_d;
   logic [6:0]       seg_d;
   logic             dp_d;

   function automatic logic [6:0] decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign tick = (cnt == CNT_LAST);
   assign snap = tick && ((state == ST_DARK) || (idx == 2'd3));

   // zero_from[k]: shadow nibbles k..3 are all zero
   always_comb begin
      zero_from    = '0;
      zero_from[3] = (sh_value[15:12] == 4'h0);
      zero_from[2] = zero_from[3] && (sh_value[11:8] == 4'h0);
      zero_from[1] = zero_from[2] && (sh_value[7:4]  == 4'h0);
      zero_from[0] = zero_from[1] && (sh_value[3:0]  == 4'h0);
   end

   // Next output values are derived from the registered idx/shadow, so the
   // pins follow a tick-driven update by exactly one cycle.
   always_comb begin
      case (idx)
         2'd0:    nib = sh_value[3:0];
         2'd1:    nib = sh_value[7:4];
         2'd2:    nib = sh_value[11:8];
         default: nib = sh_value[15:12];
      endcase
      blank = (state == ST_DARK) ||
              (sh_blank_lz && (idx != 2'd0) && zero_from[idx]);
      an_d  = blank ? 4'hF  : ~(4'b0001 << idx);
      seg_d = blank ? 7'h7F : decode(nib);
      dp_d  = blank || !sh_dp_en[idx];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_DARK;
         cnt         <= '0;
         idx         <= 2'd0;
         sh_value    <= '0;
         sh_dp_en    <= '0;
         sh_blank_lz <= 1'b0;
         an_q        <= 4'hF;
         seg_q       <= 7'h7F;
         dp_q        <= 1'b1;
         frame_q     <= 1'b0;
      end else begin
         cnt     <= tick ? '0 : cnt + CNT_W'(1);
         frame_q <= snap;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         if (tick) begin
            if (snap) begin
               state       <= ST_SCAN;
               idx         <= 2'd0;
               sh_value    <= bus.value;
               sh_dp_en    <= bus.dp_en;
               sh_blank_lz <= bus.blank_lz;
            end else begin
               idx <= idx + 2'd1;
            end
         end
      end
   end

   assign bus.an    = an_q;
   assign bus.seg   = seg_q;
   assign bus.dp    = dp_q;
   assign bus.frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_total = 0;
   int   n_bad   = 0;

   logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                              7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03,
                              7'h46, 7'h21, 7'h06, 7'h0E};

   seg7_scan_driver_if bus ();

   seg7_scan_driver #(.SCAN_PERIOD(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_frame(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 64 && !seen; i++) begin
         step();
         if (bus.frame === 1'b1) seen = 1'b1;
      end
      if (!seen) check({tag, "_frame_timeout"}, {15'b0, bus.frame}, 16'd1);
   endtask

   // One digit slot: 4 samples, frame expected only on the last one if asked.
   task automatic check_slot(input string tag, input logic [3:0] an_e,
                             input logic [6:0] seg_e, input logic dp_e,
                             input bit frame_last);
      for (int i = 0; i < 4; i++) begin
         step();
         check({tag, "_an"},  {12'b0, bus.an},  {12'b0, an_e});
         check({tag, "_seg"}, {9'b0, bus.seg},  {9'b0, seg_e});
         check({tag, "_dp"},  {15'b0, bus.dp},  {15'b0, dp_e});
         check({tag, "_frame"}, {15'b0, bus.frame},
               {15'b0, (frame_last && i == 3)});
      end
   endtask

   // Called on the sample right after the reset edge, with rst just dropped;
   // value must be 16'h1234.
   task automatic dark_start(input string tag);
      check({tag, "_rst_an"},    {12'b0, bus.an},   16'hF);
      check({tag, "_rst_seg"},   {9'b0, bus.seg},   16'h7F);
      check({tag, "_rst_dp"},    {15'b0, bus.dp},   16'd1);
      check({tag, "_rst_frame"}, {15'b0, bus.frame}, 16'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check({tag, "_dark_an"},    {12'b0, bus.an},   16'hF);
         check({tag, "_dark_frame"}, {15'b0, bus.frame}, 16'd0);
      end
      step();
      check({tag, "_snap_frame"}, {15'b0, bus.frame}, 16'd1);
      check({tag, "_snap_an"},    {12'b0, bus.an},   16'hF);
      step();
      check({tag, "_lit_an"},    {12'b0, bus.an},   16'hE);
      check({tag, "_lit_seg"},   {9'b0, bus.seg},   16'h19);
      check({tag, "_lit_dp"},    {15'b0, bus.dp},   16'd1);
      check({tag, "_lit_frame"}, {15'b0, bus.frame}, 16'd0);
   endtask

   initial begin
      logic [15:0] v;
      logic [15:0] nxt;
      logic [6:0]  g;

      // 1: reset and dark start
      bus.value    = 16'h1234;
      bus.dp_en    = 4'b0000;
      bus.blank_lz = 1'b0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      dark_start("s1");

      // 2: full scan, dp on digit 2, two frames to confirm 16-cycle frame
      bus.value    = 16'h0803;
      bus.dp_en    = 4'b0100;
      bus.blank_lz = 1'b0;
      wait_frame("s2");
      for (int f = 0; f < 2; f++) begin
         check_slot("s2_d0", 4'hE, 7'h30, 1'b1, 1'b0);
         check_slot("s2_d1", 4'hD, 7'h40, 1'b1, 1'b0);
         check_slot("s2_d2", 4'hB, 7'h00, 1'b0, 1'b0);
         check_slot("s2_d3", 4'h7, 7'h40, 1'b1, 1'b1);
      end

      // 3: leading-zero blanking; dp on a blanked digit stays dark
      bus.value    = 16'h0050;
      bus.dp_en    = 4'b1000;
      bus.blank_lz = 1'b1;
      wait_frame("s3");
      check_slot("s3_d0", 4'hE, 7'h40, 1'b1, 1'b0);
      check_slot("s3_d1", 4'hD, 7'h12, 1'b1, 1'b0);
      check_slot("s3_d2", 4'hF, 7'h7F, 1'b1, 1'b0);
      check_slot("s3_d3", 4'hF, 7'h7F, 1'b1, 1'b1);
      bus.value = 16'h0000;
      bus.dp_en = 4'b0000;
      wait_frame("s3z");
      check_slot("s3z_d0", 4'hE, 7'h40, 1'b1, 1'b0);
      check_slot("s3z_d1", 4'hF, 7'h7F, 1'b1, 1'b0);
      check_slot("s3z_d2", 4'hF, 7'h7F, 1'b1, 1'b0);
      check_slot("s3z_d3", 4'hF, 7'h7F, 1'b1, 1'b1);

      // 4: tear-free update mid-frame
      bus.value    = 16'h1111;
      bus.blank_lz = 1'b0;
      wait_frame("s4");
      check_slot("s4_d0", 4'hE, 7'h79, 1'b1, 1'b0);
      bus.value = 16'h2222;
      check_slot("s4_d1", 4'hD, 7'h79, 1'b1, 1'b0);
      check_slot("s4_d2", 4'hB, 7'h79, 1'b1, 1'b0);
      check_slot("s4_d3", 4'h7, 7'h79, 1'b1, 1'b1);
      check_slot("s4n_d0", 4'hE, 7'h24, 1'b1, 1'b0);
      check_slot("s4n_d1", 4'hD, 7'h24, 1'b1, 1'b0);
      check_slot("s4n_d2", 4'hB, 7'h24, 1'b1, 1'b0);
      bus.value = 16'h0000;
      check_slot("s4n_d3", 4'h7, 7'h24, 1'b1, 1'b1);

      // 5: glyph sweep; next value presented during digit 3 of each frame,
      // the last frame hands over to 16'h1234 for the reset test
      for (int k = 0; k < 16; k++) begin
         g   = glyph[k];
         nxt = (k == 15) ? 16'h1234 : 16'(k + 1) * 16'h1111;
         check_slot("s5_d0", 4'hE, g, 1'b1, 1'b0);
         check_slot("s5_d1", 4'hD, g, 1'b1, 1'b0);
         check_slot("s5_d2", 4'hB, g, 1'b1, 1'b0);
         bus.value = nxt;
         check_slot("s5_d3", 4'h7, g, 1'b1, 1'b1);
      end

      // 6: reset while digit 2 is active
      check_slot("s6_d0", 4'hE, 7'h19, 1'b1, 1'b0);
      check_slot("s6_d1", 4'hD, 7'h30, 1'b1, 1'b0);
      step();
      check("s6_d2_an",  {12'b0, bus.an}, 16'hB);
      check("s6_d2_seg", {9'b0, bus.seg}, 16'h24);
      rst = 1'b1;
      step();
      rst = 1'b0;
      dark_start("s6");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
